// File: rtl/block_collision_pkg.sv
// Shared geometry for the block grid, used by collision and by the board renderer.
// Also carries the per-frame hit record passed from the scan to the report stage.
package block_collision_pkg;

    localparam int unsigned GEO_W      = 12;
    localparam int unsigned IDX_W      = 4;
    localparam int unsigned NUM_BLOCKS = 16;
    localparam int unsigned GRID_COLS  = 4;
    localparam int unsigned HOR0       = 100;
    localparam int unsigned HOR_STEP   = 160;
    localparam int unsigned VER0       = 60;
    localparam int unsigned VER_STEP   = 70;
    localparam int unsigned B_WIDTH    = 100;
    localparam int unsigned B_HEIGHT   = 50;
    localparam int unsigned BALL_SIZE  = 10;

    typedef struct packed {
        logic             hit;
        logic [IDX_W-1:0] idx;
        logic             flip_y;
    } hit_rec_t;

    // Left edge of the block at grid index idx
    function automatic logic [GEO_W-1:0] blk_x0(input logic [IDX_W-1:0] idx);
        return GEO_W'(HOR0 + (32'(idx) % GRID_COLS) * HOR_STEP);
    endfunction

    // Top edge of the block at grid index idx
    function automatic logic [GEO_W-1:0] blk_y0(input logic [IDX_W-1:0] idx);
        return GEO_W'(VER0 + (32'(idx) / GRID_COLS) * VER_STEP);
    endfunction

endpackage

// File: rtl/block_collision_rect_overlap.sv
// Inclusive rectangle intersection (a against b), plus whether a's centre x lies
// within b's horizontal span. Purely combinational.
module rect_overlap
    import block_collision_pkg::*;
(
    input  logic [GEO_W-1:0] a_x0,
    input  logic [GEO_W-1:0] a_y0,
    input  logic [GEO_W-1:0] a_x1,
    input  logic [GEO_W-1:0] a_y1,
    input  logic [GEO_W-1:0] a_cx,
    input  logic [GEO_W-1:0] b_x0,
    input  logic [GEO_W-1:0] b_y0,
    input  logic [GEO_W-1:0] b_x1,
    input  logic [GEO_W-1:0] b_y1,
    output logic             overlap_c,
    output logic             cx_inside_c
);

    assign overlap_c   = (a_x0 <= b_x1) && (a_x1 >= b_x0) &&
                         (a_y0 <= b_y1) && (a_y1 >= b_y0);
    assign cx_inside_c = (a_cx >= b_x0) && (a_cx <= b_x1);

endmodule

// File: rtl/block_collision.sv
// Per-frame ball/block collision scan owning the destroyed-block map.
// Optional hit counter on score is built when BLOCK_SCORE_EN is defined.
module block_collision
    import block_collision_pkg::*;
(
    input  logic                  pclk,
    input  logic                  reset,
    input  logic                  vblnk_in,
    input  logic                  ball_en,
    input  logic [10:0]           ball_x,
    input  logic [10:0]           ball_y,
    output logic [NUM_BLOCKS-1:0] blocks_out,
    output logic                  hit,
    output logic [IDX_W-1:0]      hit_idx,
    output logic                  flip_x,
    output logic                  flip_y,
    output logic                  all_clear,
    output logic [15:0]           score
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SCAN   = 2'd1;
    localparam logic [1:0] ST_REPORT = 2'd2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BLOCKS - 1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             vblnk_d;
    logic             tick_c;
    logic             start_c;
    logic             scan_c;
    logic             report_c;
    logic [IDX_W-1:0] idx;
    logic [GEO_W-1:0] bx_q;
    logic [GEO_W-1:0] by_q;
    logic [GEO_W-1:0] blk_x_c;
    logic [GEO_W-1:0] blk_y_c;
    logic             overlap_c;
    logic             cx_inside_c;
    hit_rec_t         found;
    hit_rec_t         rep;

    assign tick_c  = vblnk_in & ~vblnk_d;
    assign blk_x_c = blk_x0(idx);
    assign blk_y_c = blk_y0(idx);

    rect_overlap u_rect_overlap (
        .a_x0        (bx_q),
        .a_y0        (by_q),
        .a_x1        (bx_q + GEO_W'(BALL_SIZE)),
        .a_y1        (by_q + GEO_W'(BALL_SIZE)),
        .a_cx        (bx_q + GEO_W'(BALL_SIZE / 2)),
        .b_x0        (blk_x_c),
        .b_y0        (blk_y_c),
        .b_x1        (blk_x_c + GEO_W'(B_WIDTH)),
        .b_y1        (blk_y_c + GEO_W'(B_HEIGHT)),
        .overlap_c   (overlap_c),
        .cx_inside_c (cx_inside_c)
    );

    // State register
    always_ff @(posedge pclk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (tick_c && ball_en) state_nxt = ST_SCAN;
            ST_SCAN:   if (idx == LAST_IDX)   state_nxt = ST_REPORT;
            ST_REPORT: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // FSM control strobes
    always_comb begin
        start_c  = 1'b0;
        scan_c   = 1'b0;
        report_c = 1'b0;
        case (state)
            ST_IDLE:   start_c  = tick_c & ball_en;
            ST_SCAN:   scan_c   = 1'b1;
            ST_REPORT: report_c = 1'b1;
            default:   ;
        endcase
    end

    // Scan datapath: the report stage registers the record once more before the pulses
    always_ff @(posedge pclk) begin
        if (reset) begin
            vblnk_d    <= 1'b0;
            idx        <= '0;
            bx_q       <= '0;
            by_q       <= '0;
            found      <= '0;
            rep        <= '0;
            blocks_out <= '0;
            hit        <= 1'b0;
            hit_idx    <= '0;
            flip_x     <= 1'b0;
            flip_y     <= 1'b0;
            all_clear  <= 1'b0;
        end else begin
            vblnk_d <= vblnk_in;
            if (start_c) begin
                bx_q  <= GEO_W'(ball_x);
                by_q  <= GEO_W'(ball_y);
                idx   <= '0;
                found <= '0;
            end
            if (scan_c) begin
                idx <= idx + IDX_W'(1);
                if (!found.hit && overlap_c && !blocks_out[idx]) begin
                    found.hit    <= 1'b1;
                    found.idx    <= idx;
                    found.flip_y <= cx_inside_c;
                end
            end
            rep     <= report_c ? found : '0;
            hit     <= rep.hit;
            flip_y  <= rep.hit & rep.flip_y;
            flip_x  <= rep.hit & ~rep.flip_y;
            if (rep.hit) begin
                hit_idx             <= rep.idx;
                blocks_out[rep.idx] <= 1'b1;
            end
            all_clear <= &blocks_out;
        end
    end

`ifdef BLOCK_SCORE_EN
    // Saturating destroyed-block counter, steps together with the hit pulse
    always_ff @(posedge pclk) begin
        if (reset)                        score <= '0;
        else if (rep.hit && score != '1)  score <= score + 16'd1;
    end
`else
    assign score = '0;
`endif

endmodule

// File: tb/tb_block_collision.sv
// Directed and randomized frames for block_collision, checked against a grid-level
// model of which block the ball touches first.
module tb_block_collision;

    logic        pclk = 1'b0;
    logic        reset;
    logic        vblnk_in;
    logic        ball_en;
    logic [10:0] ball_x;
    logic [10:0] ball_y;
    logic [15:0] blocks_out;
    logic        hit;
    logic [3:0]  hit_idx;
    logic        flip_x;
    logic        flip_y;
    logic        all_clear;
    logic [15:0] score;

    int passed = 0;
    int total  = 0;
    int fails  = 0;
    bit [15:0] map_m;
    int        score_m;

    block_collision dut (
        .pclk       (pclk),
        .reset      (reset),
        .vblnk_in   (vblnk_in),
        .ball_en    (ball_en),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .blocks_out (blocks_out),
        .hit        (hit),
        .hit_idx    (hit_idx),
        .flip_x     (flip_x),
        .flip_y     (flip_y),
        .all_clear  (all_clear),
        .score      (score)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge pclk);
        #1;
    endtask

    function automatic int exp_score();
`ifdef BLOCK_SCORE_EN
        return score_m;
`else
        return 0;
`endif
    endfunction

    // Grid model: first live block whose rectangle touches the ball square
    task automatic model(input int x, input int y, input bit en,
                         output bit h, output int hi, output bit fy);
        h = 0; hi = 0; fy = 0;
        if (!en) return;
        for (int i = 0; i < 16; i++) begin
            int l, t;
            l = 100 + (i % 4) * 160;
            t = 60 + (i / 4) * 70;
            if (!h && !map_m[i] && x <= l + 100 && x + 10 >= l &&
                y <= t + 50 && y + 10 >= t) begin
                h  = 1;
                hi = i;
                fy = (x + 5 >= l) && (x + 5 <= l + 100);
            end
        end
    endtask

    task automatic do_reset;
        @(negedge pclk);
        reset = 1'b1; vblnk_in = 1'b0;
        step; step;
        chk("rst_map", 32'(blocks_out), 0);
        chk("rst_pulses", {hit, flip_x, flip_y, all_clear, hit_idx}, 0);
        chk("rst_score", 32'(score), 0);
        @(negedge pclk);
        reset = 1'b0;
        map_m = '0; score_m = 0;
    endtask

    // One frame; abort_at >= 0 pulses reset after that scan edge
    task automatic frame(input int x, input int y, input bit en, input int abort_at);
        bit eh, efy, seen;
        int ehi;
        model(x, y, en, eh, ehi, efy);
        @(negedge pclk);
        ball_x = 11'(x); ball_y = 11'(y); ball_en = en; vblnk_in = 1'b1;
        step;                                   // E0 samples the rise
        seen = hit;
        @(negedge pclk);
        ball_x = 11'($urandom_range(0, 2047));  // must not affect the latched ball
        ball_y = 11'($urandom_range(0, 2047));
        for (int k = 1; k <= 17; k++) begin
            step;
            seen |= hit;
            if (k == 5 || k == 9) begin         // bounce vblnk mid-scan: second rise is ignored
                @(negedge pclk);
                vblnk_in = (k == 9);
            end
            if (k == abort_at) begin
                @(negedge pclk);
                reset = 1'b1; vblnk_in = 1'b0;
                step;
                chk("abort_map", 32'(blocks_out), 0);
                chk("abort_pulses", {hit, flip_x, flip_y, all_clear, hit_idx}, 0);
                chk("abort_score", 32'(score), 0);
                @(negedge pclk);
                reset = 1'b0;
                map_m = '0; score_m = 0;
                step; step;
                chk("abort_nohit", 32'(hit), 0);
                return;
            end
        end
        chk("early_hit", 32'(seen), 0);
        step;                                   // E18
        if (eh) begin
            map_m[ehi] = 1'b1;
            if (score_m < 65535) score_m++;
        end
        chk("hit", 32'(hit), 32'(eh));
        chk("flip_y", 32'(flip_y), 32'(eh & efy));
        chk("flip_x", 32'(flip_x), 32'(eh & ~efy));
        chk("blocks_out", 32'(blocks_out), 32'(map_m));
        if (eh) chk("hit_idx", 32'(hit_idx), 32'(ehi));
        @(negedge pclk);
        vblnk_in = 1'b0;
        step;                                   // E19
        chk("hit_clear", 32'(hit | flip_x | flip_y), 0);
        chk("all_clear", 32'(all_clear), 32'(&map_m));
        chk("score", 32'(score), 32'(exp_score()));
        step; step;
    endtask

    initial begin
        reset = 1'b1; vblnk_in = 1'b0; ball_en = 1'b0; ball_x = '0; ball_y = '0;
        map_m = '0; score_m = 0;
        repeat (3) @(posedge pclk);
        #1;
        chk("init_map", 32'(blocks_out), 0);
        chk("init_pulses", {hit, flip_x, flip_y, all_clear, hit_idx}, 0);
        @(negedge pclk);
        reset = 1'b0;

        frame(150, 70, 1'b1, -1);
        chk("t1_map", 32'(blocks_out), 32'h0001);
        frame(92, 80, 1'b1, -1);
        do_reset;
        frame(92, 80, 1'b1, -1);
        frame(260, 280, 1'b1, -1);
        chk("t3_bit13", 32'(blocks_out[13]), 1);
        frame(260, 280, 1'b1, -1);
        frame(260, 280, 1'b1, -1);

        frame(300, 150, 1'b0, -1);
        frame(300, 150, 1'b1, 7);
        frame(300, 150, 1'b1, -1);

        for (int i = 0; i < 3; i++) frame(700, 500, 1'b1, -1);

        for (int i = 0; i < 16; i++)
            frame(100 + (i % 4) * 160 + 45, 60 + (i / 4) * 70 + 20, 1'b1, -1);
        chk("sweep_all_clear", 32'(all_clear), 1);

        do_reset;
        for (int i = 0; i < 40; i++)
            frame(int'($urandom_range(0, 720)), int'($urandom_range(0, 360)),
                  $urandom_range(0, 7) != 0, -1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
